// File: rtl/dfthijack_pkg.sv
// rtl/dfthijack_pkg.sv - shared types and constants for the regulation-clock hijack controller
package dfthijack_pkg;

  // Controller states; RELOCK lasts exactly one cycle on the way back to LOCKED
  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEYHALF  = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_RELOCK   = 2'd3
  } state_e;

  // Register map of the byte-wide test interface
  localparam logic [1:0] ADDR_KEY  = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DIV  = 2'd2;
  localparam logic [1:0] ADDR_LOCK = 2'd3;

  // Default two-byte unlock sequence
  localparam logic [7:0] KEY0_DEFAULT = 8'hA5;
  localparam logic [7:0] KEY1_DEFAULT = 8'h5A;

endpackage

// File: rtl/dfthijack_clkdiv.sv
// rtl/dfthijack_clkdiv.sv - test-clock divider with run gate, sync clear and per-toggle half-period load
module dfthijack_clkdiv #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [DIV_W-1:0] half,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] half_q;
  logic             clk_q;

  // Count run cycles; toggle after half_q+1 of them and pick up a new half-period only at a toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= '0;
      clk_q  <= 1'b0;
    end else if (clr || !run) begin
      cnt_q  <= '0;
      half_q <= half;
      clk_q  <= 1'b0;
    end else if (cnt_q == half_q) begin
      cnt_q  <= '0;
      half_q <= half;
      clk_q  <= ~clk_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign clk_out = clk_q;

endmodule

// File: rtl/dfthijack_regclk_ctrl.sv
// rtl/dfthijack_regclk_ctrl.sv - key-locked test access controller driving the regulation-clock hijack cell
module dfthijack_regclk_ctrl
  import dfthijack_pkg::*;
#(
  parameter logic [7:0]        KEY0     = KEY0_DEFAULT,
  parameter logic [7:0]        KEY1     = KEY1_DEFAULT,
  parameter int                WDOG_W   = 12,
  parameter logic [WDOG_W-1:0] WDOG_MAX = 12'd4000,
  parameter int                DIV_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CELG,
  input  logic       CELV,
  input  logic       CELSUB,
  input  logic       ten_wr_valid,
  output logic       ten_wr_ready,
  input  logic [1:0] ten_wr_addr,
  input  logic [7:0] ten_wr_data,
  output logic       ten_HJregulationclkenable,
  output logic       ten_HJregulationclkstatus,
  output logic       HJregulationclk,
  output logic       ten_unlocked,
  output logic       ten_wdog_trip
);

  // Last idle count before the watchdog fires on the following idle cycle
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_MAX - 1'b1;

  state_e            state_q;
  state_e            state_d;
  logic              en_q;
  logic              st_q;
  logic [DIV_W-1:0]  div_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              trip_q;
  logic              accept;
  logic              wdog_hit;
  logic              relock_entry;
  logic              clk_run;

  // Supply and substrate pins carry no logic function
  logic unused_supply_pins;
  assign unused_supply_pins = ^{CELG, CELV, CELSUB};

  assign ten_wr_ready = (state_q != ST_RELOCK);
  assign accept       = ten_wr_valid && ten_wr_ready;
  // A write landing on the final idle cycle keeps the block unlocked
  assign wdog_hit     = (state_q == ST_UNLOCKED) && !accept && (wdog_q == WDOG_LAST);
  assign relock_entry = (state_d == ST_RELOCK);
  assign clk_run      = (state_q == ST_UNLOCKED) && en_q;

  // Next-state decode: unlock key sequence, voluntary relock and watchdog relock
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOCKED: begin
        if (accept && (ten_wr_addr == ADDR_KEY) && (ten_wr_data == KEY0)) begin
          state_d = ST_KEYHALF;
        end
      end
      ST_KEYHALF: begin
        if (accept) begin
          if ((ten_wr_addr == ADDR_KEY) && (ten_wr_data == KEY1)) begin
            state_d = ST_UNLOCKED;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if ((accept && (ten_wr_addr == ADDR_LOCK)) || wdog_hit) begin
          state_d = ST_RELOCK;
        end
      end
      ST_RELOCK: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Hijack control and divider registers; cleared on the edge that enters RELOCK
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      st_q  <= 1'b0;
      div_q <= '0;
    end else if (relock_entry) begin
      en_q  <= 1'b0;
      st_q  <= 1'b0;
      div_q <= '0;
    end else if ((state_q == ST_UNLOCKED) && accept) begin
      case (ten_wr_addr)
        ADDR_CTRL: begin
          en_q <= ten_wr_data[0];
          st_q <= ten_wr_data[1];
        end
        ADDR_DIV: begin
          div_q <= ten_wr_data[DIV_W-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Idle watchdog: counts unlocked cycles without an accepted write, trip pulse aligns with RELOCK
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      trip_q <= 1'b0;
    end else begin
      trip_q <= wdog_hit;
      if ((state_q != ST_UNLOCKED) || accept) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  dfthijack_clkdiv #(
    .DIV_W (DIV_W)
  ) u_clkdiv (
    .clk     (clk),
    .rst     (rst),
    .run     (clk_run),
    .clr     (relock_entry),
    .half    (div_q),
    .clk_out (HJregulationclk)
  );

  assign ten_HJregulationclkenable = en_q;
  assign ten_HJregulationclkstatus = st_q;
  assign ten_unlocked              = (state_q == ST_UNLOCKED);
  assign ten_wdog_trip             = trip_q;

endmodule

// File: tb/tb_dfthijack_regclk_ctrl.sv
// tb/tb_dfthijack_regclk_ctrl.sv - directed and randomized self-checking bench for dfthijack_regclk_ctrl
module tb_dfthijack_regclk_ctrl;

  localparam logic [7:0] K0   = 8'hA5;
  localparam logic [7:0] K1   = 8'h5A;
  localparam int         WMAX = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       CELG;
  logic       CELV;
  logic       CELSUB;
  logic       ten_wr_valid;
  logic [1:0] ten_wr_addr;
  logic [7:0] ten_wr_data;
  logic       ten_wr_ready;
  logic       hj_en;
  logic       hj_st;
  logic       hj_clk;
  logic       unl;
  logic       trip;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: mode 0 locked, 1 first key seen, 2 unlocked, 3 relocking
  int m_mode  = 0;
  int m_idle  = 0;
  int m_phase = 0;
  int m_half  = 0;
  int m_div   = 0;
  bit m_en    = 1'b0;
  bit m_st    = 1'b0;
  bit m_clk   = 1'b0;
  bit m_trip  = 1'b0;

  always #5 clk = ~clk;

  dfthijack_regclk_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .CELG                      (CELG),
    .CELV                      (CELV),
    .CELSUB                    (CELSUB),
    .ten_wr_valid              (ten_wr_valid),
    .ten_wr_ready              (ten_wr_ready),
    .ten_wr_addr               (ten_wr_addr),
    .ten_wr_data               (ten_wr_data),
    .ten_HJregulationclkenable (hj_en),
    .ten_HJregulationclkstatus (hj_st),
    .HJregulationclk           (hj_clk),
    .ten_unlocked              (unl),
    .ten_wdog_trip             (trip)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented in that cycle
  task automatic model_step(input bit v, input logic [1:0] a, input logic [7:0] d, input bit r);
    bit acc;
    int nxt;
    if (r) begin
      m_mode = 0; m_idle = 0; m_phase = 0; m_half = 0; m_div = 0;
      m_en = 0; m_st = 0; m_clk = 0; m_trip = 0;
      return;
    end
    acc = v && (m_mode != 3);
    // test clock: elapsed running cycles since last toggle reach the half period in force
    if ((m_mode == 2) && m_en) begin
      m_phase++;
      if (m_phase == m_half + 1) begin
        m_clk   = !m_clk;
        m_phase = 0;
        m_half  = m_div;
      end
    end else begin
      m_clk   = 1'b0;
      m_phase = 0;
      m_half  = m_div;
    end
    m_trip = 1'b0;
    nxt    = m_mode;
    case (m_mode)
      0: if (acc && a == 2'd0 && d == K0) nxt = 1;
      1: if (acc) nxt = (a == 2'd0 && d == K1) ? 2 : 0;
      2: begin
        if (acc) begin
          m_idle = 0;
          if (a == 2'd1) begin
            m_en = d[0];
            m_st = d[1];
          end else if (a == 2'd2) begin
            m_div = int'(d);
          end else if (a == 2'd3) begin
            nxt = 3;
          end
        end else begin
          m_idle++;
          if (m_idle == WMAX) begin
            m_trip = 1'b1;
            nxt    = 3;
          end
        end
      end
      default: nxt = 0;
    endcase
    if (nxt == 3) begin
      m_en = 0; m_st = 0; m_div = 0; m_clk = 0; m_phase = 0;
    end
    if (nxt != 2) m_idle = 0;
    m_mode = nxt;
  endtask

  task automatic check_all();
    chk("ready",    ten_wr_ready, m_mode != 3);
    chk("unlocked", unl,          m_mode == 2);
    chk("enable",   hj_en,        m_en);
    chk("status",   hj_st,        m_st);
    chk("hjclk",    hj_clk,       m_clk);
    chk("trip",     trip,         m_trip);
  endtask

  task automatic cycle(input bit v, input logic [1:0] a, input logic [7:0] d, input bit r);
    rst          = r;
    ten_wr_valid = v;
    ten_wr_addr  = a;
    ten_wr_data  = d;
    @(posedge clk);
    model_step(v, a, d, r);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cycle(1'b1, a, d, 1'b0);
  endtask

  task automatic idle();
    logic [1:0] a;
    logic [7:0] d;
    a = 2'($urandom_range(0, 3));
    d = 8'($urandom_range(0, 255));
    cycle(1'b0, a, d, 1'b0);
  endtask

  task automatic unlock();
    wr(2'd0, K0);
    wr(2'd0, K1);
  endtask

  initial begin
    int k;
    int r;
    CELG = 1'b0; CELV = 1'b1; CELSUB = 1'b0;
    rst = 1'b1; ten_wr_valid = 1'b0; ten_wr_addr = 2'd0; ten_wr_data = 8'd0;

    // reset state
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    chk("rst_ready", ten_wr_ready, 1'b1);
    chk("rst_unlocked", unl, 1'b0);
    chk("rst_hjclk", hj_clk, 1'b0);
    idle();

    // plain unlock
    unlock();
    chk("unlock_unlocked", unl, 1'b1);
    chk("unlock_enable", hj_en, 1'b0);
    chk("unlock_status", hj_st, 1'b0);
    wr(2'd3, 8'h00);
    idle();

    // interrupted key sequence stays locked
    wr(2'd0, K0);
    wr(2'd1, 8'h03);
    wr(2'd0, K1);
    chk("badkey_unlocked", unl, 1'b0);
    chk("badkey_enable", hj_en, 1'b0);

    // divider 2: first rise 3 cycles after enable, period 6
    unlock();
    wr(2'd2, 8'd2);
    wr(2'd1, 8'h01);
    chk("div_enable", hj_en, 1'b1);
    chk("div_status", hj_st, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      idle();
      chk($sformatf("div2_clk_k%0d", i), hj_clk, ((i / 3) % 2) == 1);
    end

    // write on the last idle cycle beats the watchdog
    wr(2'd1, 8'h01);
    repeat (WMAX - 1) idle();
    wr(2'd1, 8'h01);
    chk("wdog_race_trip", trip, 1'b0);
    chk("wdog_race_unlocked", unl, 1'b1);

    // full idle window trips the watchdog
    k = 0;
    do begin
      idle();
      k++;
    end while (!trip && k < WMAX + 100);
    chk_int("wdog_trip_cycle", k, WMAX);
    chk("wdog_relock_ready", ten_wr_ready, 1'b0);
    idle();
    chk("wdog_after_trip", trip, 1'b0);
    chk("wdog_after_ready", ten_wr_ready, 1'b1);
    chk("wdog_after_enable", hj_en, 1'b0);
    chk("wdog_after_hjclk", hj_clk, 1'b0);

    // voluntary relock with valid held through the stall
    unlock();
    wr(2'd1, 8'h03);
    chk("vol_enable", hj_en, 1'b1);
    chk("vol_status", hj_st, 1'b1);
    wr(2'd3, 8'h00);
    chk("vol_ready", ten_wr_ready, 1'b0);
    chk("vol_enable_clr", hj_en, 1'b0);
    chk("vol_status_clr", hj_st, 1'b0);
    wr(2'd0, K0);
    chk("vol_ready_back", ten_wr_ready, 1'b1);
    wr(2'd0, K0);
    wr(2'd0, K1);
    chk("vol_stalled_key_unlocks", unl, 1'b1);

    // reset while the test clock is high
    wr(2'd2, 8'd1);
    wr(2'd1, 8'h01);
    k = 0;
    do begin
      idle();
      k++;
    end while (!hj_clk && k < 20);
    chk("mid_clk_high", hj_clk, 1'b1);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    chk("mid_rst_hjclk", hj_clk, 1'b0);
    chk("mid_rst_unlocked", unl, 1'b0);
    chk("mid_rst_ready", ten_wr_ready, 1'b1);
    chk("mid_rst_enable", hj_en, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r == 0) cycle(1'b0, 2'd0, 8'd0, 1'b1);
      else if (m_mode == 0 && r < 40) wr(2'd0, K0);
      else if (m_mode == 1 && r < 75) wr(2'd0, K1);
      else if (m_mode == 2 && r < 20) wr(2'd2, 8'($urandom_range(0, 3)));
      else if (m_mode == 2 && r < 35) wr(2'd1, 8'($urandom_range(0, 3)));
      else if (r < 45) cycle(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
      else idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
